grn_node_param: RTL and testbench
=================================

GRN_NODE_PARAM -- requirements
Module: grn_node_param

Interface
REQ-001: Parameter WIDTH, default 1, bit width of each node state value.
REQ-002: Parameter DELAY_S0, default 2, number of start_s0 strobes per s0 update (legal 1..255).
REQ-003: Parameter DELAY_S1, default 1, number of start_s1 strobes per s1 update (legal 1..255).
REQ-004: Parameter CNT_W, default 16, width of each change counter.
REQ-005: clk  input  1  single clock; all state changes on its rising edge.
REQ-006: rst  input  1  reset, synchronous, active-high.
REQ-007: start  input  1  global enable; while 0, start_s0 and start_s1 are ignored.
REQ-008: reset_nos  input  1  network re-initialise, load init_state into both channels.
REQ-009: start_s0  input  1  update strobe for channel s0.
REQ-010: start_s1  input  1  update strobe for channel s1.
REQ-011: init_state  input  WIDTH  value loaded into s0 and s1 on reset_nos.
REQ-012: next_s0  input  WIDTH  next-state value for s0, sampled on s0 update cycle.
REQ-013: next_s1  input  WIDTH  next-state value for s1, sampled on s1 update cycle.
REQ-014: s0  output  WIDTH  registered state of channel s0.
REQ-015: s1  output  WIDTH  registered state of channel s1.
REQ-016: upd_s0, upd_s1  output  1 each  one-cycle pulse, high in the cycle the channel shows a newly sampled value.
REQ-017: chg_s0, chg_s1  output  1 each  one-cycle pulse, high with upd_x only when the sampled value differs from the previous value.
REQ-018: chg_cnt_s0, chg_cnt_s1  output  CNT_W each  saturating count of value changes per channel.
REQ-019: stable  output  1  high when the most recent update of each channel produced no change.

Function
REQ-020: Priority per cycle SHALL be rst > reset_nos > strobe processing; channels SHALL be processed independently.
REQ-021: Each channel x SHALL hold a phase counter ph_x in 0..DELAY_x-1, 8 bits wide.
REQ-022: Valid strobe = start & start_x & ~reset_nos & ~rst.
REQ-023: On a valid strobe with ph_x == DELAY_x-1: s_x <= next_x, ph_x <= 0, upd_x <= 1 next cycle.
REQ-024: On a valid strobe with ph_x < DELAY_x-1: ph_x <= ph_x+1, s_x unchanged, upd_x <= 0.
REQ-025: No valid strobe: s_x, ph_x hold; upd_x, chg_x deassert.
REQ-026: reset_nos SHALL load s0 <= init_state, s1 <= init_state, ph_x <= DELAY_x-1 (first valid strobe after it updates), clear chg_cnt_x, clear stable, clear upd_x/chg_x.
REQ-027: chg_x SHALL assert in the same cycle as upd_x iff next_x sampled != prior s_x.
REQ-028: chg_cnt_x SHALL increment by 1 on each update with change and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-029: Per-channel flag nc_x SHALL be set on an update without change, cleared on an update with change; stable = nc_s0 & nc_s1.
REQ-030: With DELAY_x = 1, every valid strobe SHALL update s_x (ph_x stays 0).
REQ-031: Latency strobe-to-output SHALL be exactly one clock; strobes on consecutive cycles SHALL each be counted.
REQ-032: Simultaneous start_s0 and start_s1 SHALL be handled in the same cycle without interaction.
REQ-033: reset_nos coincident with a strobe SHALL discard the strobe entirely.

Reset
REQ-034: On rst: s0, s1 = 0; ph_x = 0; upd_x, chg_x = 0; chg_cnt_x = 0; stable = 0.
REQ-035: rst asserted mid-operation SHALL override all other inputs in that cycle; no partial update.
REQ-036: After rst without reset_nos, s_x SHALL first update on the DELAY_x-th valid strobe.

Verification
REQ-037: WIDTH=1, DELAY_S0=2: reset_nos init_state=1, then four start_s0 pulses with next_s0=0 -> s0 becomes 0 after pulse 1, pulses 2 and 4 give no upd, pulse 3 gives upd_s0=1, chg_s0=0.
REQ-038: DELAY_S1=1, start=0 with start_s1 pulses -> s1 and all flags unchanged; start=1 -> each pulse yields upd_s1.
REQ-039: CNT_W=2, toggle next_s1 on 5 consecutive updates -> chg_cnt_s1 reads 1,2,3,3,3.
REQ-040: reset_nos and start_s0 in same cycle, init_state=1, next_s0=0 -> s0=1, upd_s0=0, ph_s0=DELAY_S0-1.
REQ-041: Both channels update with unchanged values -> stable=1; one channel then changes -> stable=0 in the same cycle as chg.
REQ-042: rst asserted during strobe burst, WIDTH=4, DELAY_S0=3 -> next cycle s0=0, counters 0; first update after release on 3rd valid strobe.

Source files
------------

// File: rtl/grn_node_param.sv
// Two-channel gene-regulatory-network node: each channel samples its next state
// every DELAY_x-th strobe and reports update, change, change count and stability.
module grn_node_param #(
  parameter int WIDTH    = 1,
  parameter int DELAY_S0 = 2,
  parameter int DELAY_S1 = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reset_nos,
  input  logic             start_s0,
  input  logic             start_s1,
  input  logic [WIDTH-1:0] init_state,
  input  logic [WIDTH-1:0] next_s0,
  input  logic [WIDTH-1:0] next_s1,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic             upd_s0,
  output logic             upd_s1,
  output logic             chg_s0,
  output logic             chg_s1,
  output logic [CNT_W-1:0] chg_cnt_s0,
  output logic [CNT_W-1:0] chg_cnt_s1,
  output logic             stable
);

  localparam logic [7:0] PH_LAST [2] = '{8'(DELAY_S0 - 1), 8'(DELAY_S1 - 1)};

  logic [WIDTH-1:0] nxt    [2];
  logic             strobe [2];
  logic [WIDTH-1:0] st_q   [2];
  logic [7:0]       ph_q   [2];
  logic             upd_q  [2];
  logic             chg_q  [2];
  logic             nc_q   [2];
  logic [CNT_W-1:0] cnt_q  [2];

  assign nxt[0]    = next_s0;
  assign nxt[1]    = next_s1;
  assign strobe[0] = start & start_s0;
  assign strobe[1] = start & start_s1;

  // Both channels live in one block so each array has a single driver; the
  // channels never read each other's state, so they stay independent.
  // NOTE: every register here uses <= so all channels see pre-edge values.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        st_q[c]  <= '0;
        ph_q[c]  <= '0;
        upd_q[c] <= 1'b0;
        chg_q[c] <= 1'b0;
        nc_q[c]  <= 1'b0;
        cnt_q[c] <= '0;
      end else if (reset_nos) begin
        // Parking the phase at its last value makes the next strobe update.
        st_q[c]  <= init_state;
        ph_q[c]  <= PH_LAST[c];
        upd_q[c] <= 1'b0;
        chg_q[c] <= 1'b0;
        nc_q[c]  <= 1'b0;
        cnt_q[c] <= '0;
      end else begin
        upd_q[c] <= 1'b0;
        chg_q[c] <= 1'b0;
        if (strobe[c]) begin
          if (ph_q[c] == PH_LAST[c]) begin
            ph_q[c]  <= '0;
            st_q[c]  <= nxt[c];
            upd_q[c] <= 1'b1;
            if (nxt[c] != st_q[c]) begin
              chg_q[c] <= 1'b1;
              nc_q[c]  <= 1'b0;
              if (cnt_q[c] != {CNT_W{1'b1}})
                cnt_q[c] <= cnt_q[c] + 1'b1;
            end else begin
              nc_q[c] <= 1'b1;
            end
          end else begin
            ph_q[c] <= ph_q[c] + 8'd1;
          end
        end
      end
    end
  end

  assign s0         = st_q[0];
  assign s1         = st_q[1];
  assign upd_s0     = upd_q[0];
  assign upd_s1     = upd_q[1];
  assign chg_s0     = chg_q[0];
  assign chg_s1     = chg_q[1];
  assign chg_cnt_s0 = cnt_q[0];
  assign chg_cnt_s1 = cnt_q[1];
  assign stable     = nc_q[0] & nc_q[1];

endmodule

// File: tb/tb_grn_node_param.sv
// Bench for grn_node_param: two instances (default and WIDTH=4/DELAY_S0=3/CNT_W=2)
// driven by shared stimulus and compared every cycle against a strobe-countdown model.
module tb_grn_node_param;

  logic       clk = 1'b0;
  logic       rst, start, reset_nos, start_s0, start_s1;
  logic [3:0] init_state, next_s0, next_s1;

  logic        a_s0, a_s1, a_upd0, a_upd1, a_chg0, a_chg1, a_stable;
  logic [15:0] a_cnt0, a_cnt1;
  logic [3:0]  b_s0, b_s1;
  logic        b_upd0, b_upd1, b_chg0, b_chg1, b_stable;
  logic [1:0]  b_cnt0, b_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grn_node_param u_a (
    .clk(clk), .rst(rst), .start(start), .reset_nos(reset_nos),
    .start_s0(start_s0), .start_s1(start_s1),
    .init_state(init_state[0]), .next_s0(next_s0[0]), .next_s1(next_s1[0]),
    .s0(a_s0), .s1(a_s1), .upd_s0(a_upd0), .upd_s1(a_upd1),
    .chg_s0(a_chg0), .chg_s1(a_chg1),
    .chg_cnt_s0(a_cnt0), .chg_cnt_s1(a_cnt1), .stable(a_stable)
  );

  grn_node_param #(.WIDTH(4), .DELAY_S0(3), .DELAY_S1(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start), .reset_nos(reset_nos),
    .start_s0(start_s0), .start_s1(start_s1),
    .init_state(init_state), .next_s0(next_s0), .next_s1(next_s1),
    .s0(b_s0), .s1(b_s1), .upd_s0(b_upd0), .upd_s1(b_upd1),
    .chg_s0(b_chg0), .chg_s1(b_chg1),
    .chg_cnt_s0(b_cnt0), .chg_cnt_s1(b_cnt1), .stable(b_stable)
  );

  // Reference model: per instance d and channel c, "rem" is how many more
  // valid strobes are needed before the channel samples its next value.
  int dly  [2][2] = '{'{2, 1}, '{3, 1}};
  int mask [2]    = '{1, 15};
  int cmax [2]    = '{65535, 3};
  int m_s [2][2], m_rem [2][2], m_upd [2][2], m_chg [2][2], m_cnt [2][2], m_nc [2][2];

  task automatic model_tick();
    int nx;
    bit strb;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        nx   = int'(c == 0 ? next_s0 : next_s1) & mask[d];
        strb = start && (c == 0 ? start_s0 : start_s1);
        m_upd[d][c] = 0;
        m_chg[d][c] = 0;
        if (rst) begin
          m_s[d][c] = 0; m_rem[d][c] = dly[d][c]; m_cnt[d][c] = 0; m_nc[d][c] = 0;
        end else if (reset_nos) begin
          m_s[d][c] = int'(init_state) & mask[d]; m_rem[d][c] = 1;
          m_cnt[d][c] = 0; m_nc[d][c] = 0;
        end else if (strb) begin
          if (m_rem[d][c] == 1) begin
            m_upd[d][c] = 1;
            m_chg[d][c] = (nx != m_s[d][c]) ? 1 : 0;
            m_nc[d][c]  = m_chg[d][c] ? 0 : 1;
            if (m_chg[d][c] && m_cnt[d][c] < cmax[d]) m_cnt[d][c]++;
            m_s[d][c]   = nx;
            m_rem[d][c] = dly[d][c];
          end else begin
            m_rem[d][c]--;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_s0",   32'(a_s0),   m_s[0][0]);
    check("a_s1",   32'(a_s1),   m_s[0][1]);
    check("a_upd0", 32'(a_upd0), m_upd[0][0]);
    check("a_upd1", 32'(a_upd1), m_upd[0][1]);
    check("a_chg0", 32'(a_chg0), m_chg[0][0]);
    check("a_chg1", 32'(a_chg1), m_chg[0][1]);
    check("a_cnt0", 32'(a_cnt0), m_cnt[0][0]);
    check("a_cnt1", 32'(a_cnt1), m_cnt[0][1]);
    check("a_stab", 32'(a_stable), m_nc[0][0] & m_nc[0][1]);
    check("b_s0",   32'(b_s0),   m_s[1][0]);
    check("b_s1",   32'(b_s1),   m_s[1][1]);
    check("b_upd0", 32'(b_upd0), m_upd[1][0]);
    check("b_upd1", 32'(b_upd1), m_upd[1][1]);
    check("b_chg0", 32'(b_chg0), m_chg[1][0]);
    check("b_chg1", 32'(b_chg1), m_chg[1][1]);
    check("b_cnt0", 32'(b_cnt0), m_cnt[1][0]);
    check("b_cnt1", 32'(b_cnt1), m_cnt[1][1]);
    check("b_stab", 32'(b_stable), m_nc[1][0] & m_nc[1][1]);
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs read 1 ns later.
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reset_nos = 1'b0; start_s0 = 1'b0; start_s1 = 1'b0;
    init_state = 4'h0; next_s0 = 4'h0; next_s1 = 4'h0;
    step();
    step();
    check("rst_b_s0", 32'(b_s0), 0);

    // Re-initialise to all ones, then four s0 pulses with next_s0 = 0.
    rst = 1'b0; reset_nos = 1'b1; init_state = 4'hF;
    step();
    reset_nos = 1'b0; start = 1'b1; next_s0 = 4'h0;
    for (int i = 0; i < 4; i++) begin
      start_s0 = 1'b1; step();
      if (i == 0) check("nos_first_upd_a", 32'(a_upd0), 1);
      start_s0 = 1'b0; step();
    end

    // s1 strobes ignored while start is low, honoured once it rises.
    start = 1'b0; start_s1 = 1'b1; next_s1 = 4'h5;
    repeat (3) step();
    start = 1'b1;
    repeat (3) step();

    // Toggle next_s1 on five consecutive updates; the 2-bit counter saturates.
    for (int i = 0; i < 5; i++) begin
      next_s1 = ~next_s1;
      step();
    end
    check("sat_b_cnt1", 32'(b_cnt1), 3);

    // Both channels refresh with unchanged values, then s1 changes.
    start_s0 = 1'b1; next_s0 = 4'h0; next_s1 = 4'(m_s[1][1]);
    repeat (6) step();
    check("stable_b_hi", 32'(b_stable), 1);
    next_s1 = ~next_s1;
    step();
    check("stable_b_lo", 32'(b_stable), 0);
    start_s1 = 1'b0;

    // reset_nos coincident with a strobe: the strobe is discarded.
    reset_nos = 1'b1; init_state = 4'hF; next_s0 = 4'h0;
    step();
    check("nos_strobe_b_s0", 32'(b_s0), 15);
    reset_nos = 1'b0;
    step();
    check("nos_next_upd_b", 32'(b_upd0), 1);

    // rst in the middle of a strobe burst, then the burst continues.
    for (int i = 0; i < 8; i++) begin
      rst = (i == 2);
      next_s0 = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0; start_s0 = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      reset_nos  = ($urandom_range(0, 15) == 0);
      start      = ($urandom_range(0, 3) != 0);
      start_s0   = $urandom_range(0, 1);
      start_s1   = $urandom_range(0, 1);
      init_state = 4'($urandom_range(0, 15));
      next_s0    = ($urandom_range(0, 2) == 0) ? 4'(m_s[1][0]) : 4'($urandom_range(0, 15));
      next_s1    = ($urandom_range(0, 2) == 0) ? 4'(m_s[1][1]) : 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
